// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder.
//   BCD_MAX  - largest legal decimal digit
//   BCD_ADJ  - correction added to a binary digit sum that exceeds BCD_MAX
//   DIGIT_W  - bits per packed BCD digit
//   state_t  - sequencer state encoding
package bcd_serial_adder_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single decimal digit adder with BCD correction (combinational).
// Ports:
//   x, y  - input digits (4 bits each, nominally 0..9)
//   cin   - decimal carry in
//   s     - corrected result digit
//   cout  - decimal carry out
// Digits above 9 are not rejected; they follow the same arithmetic, so the
// 5-bit intermediate sum must cover up to 15 + 15 + 1.
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] t;
    logic [DIGIT_W:0] t_adj;

    assign t     = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
    assign t_adj = t + {1'b0, BCD_ADJ};

    always_comb begin
        s    = t[DIGIT_W-1:0];
        cout = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            // Adding 6 skips the six unused codes; the low nibble is the
            // decimal digit and the carry is always one here.
            s    = t_adj[DIGIT_W-1:0];
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one digit per clock, LSD first.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active high
//   start - begin an operation (accepted only while idle)
//   a, b  - packed BCD operands, digit i at [4i+3:4i]; latched on start
//   busy  - operation in progress
//   done  - one-cycle pulse when sum/cout/err are final
//   sum   - packed BCD result (held until the next accepted start)
//   cout  - decimal carry out of the most significant digit
//   err   - some input digit of a or b was greater than 9
// Handshake: start is a request sampled on a rising edge; it is taken only
// in IDLE (busy low), including the cycle where done is high, and ignored
// otherwise. done is a single-cycle completion pulse with no back-pressure.
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      cout,
    output logic                      err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    // State is kept as a named signal so checkers can bind to it directly.
    state_t           state, state_n;
    logic [W-1:0]     a_q, a_n;
    logic [W-1:0]     b_q, b_n;
    logic             carry, carry_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [W-1:0]     sum_n;
    logic             cout_n;
    logic             err_n;
    logic             done_n;

    logic [DIGIT_W-1:0] cur_a;
    logic [DIGIT_W-1:0] cur_b;
    logic [DIGIT_W-1:0] dig_s;
    logic               dig_c;
    logic               in_err;

    assign cur_a = a_q[idx*DIGIT_W +: DIGIT_W];
    assign cur_b = b_q[idx*DIGIT_W +: DIGIT_W];

    bcd_digit_add u_digit (
        .x    (cur_a),
        .y    (cur_b),
        .cin  (carry),
        .s    (dig_s),
        .cout (dig_c)
    );

    // Flag any illegal digit on the live inputs; only used on the start edge.
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) in_err = 1'b1;
            if (b[i*DIGIT_W +: DIGIT_W] > BCD_MAX) in_err = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        carry_n = carry;
        idx_n   = idx;
        sum_n   = sum;
        cout_n  = cout;
        err_n   = err;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = b;
                    carry_n = 1'b0;
                    idx_n   = '0;
                    sum_n   = '0;
                    cout_n  = 1'b0;
                    err_n   = in_err;
                    state_n = RUN;
                end
            end
            RUN: begin
                sum_n[idx*DIGIT_W +: DIGIT_W] = dig_s;
                carry_n = dig_c;
                if (idx == LAST) begin
                    cout_n  = dig_c;
                    done_n  = 1'b1;
                    idx_n   = '0;
                    state_n = IDLE;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            carry <= carry_n;
            idx   <= idx_n;
            sum   <= sum_n;
            cout  <= cout_n;
            err   <= err_n;
            done  <= done_n;
        end
    end

    // busy follows the state register, so reset clears it asynchronously too.
    assign busy = (state == RUN);

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

  logic clk = 1'b0;
  logic rst;

  // 4-digit instance
  logic        start;
  logic [15:0] a, b, sum;
  logic        busy, done, cout, err;

  // 1-digit instance
  logic        start1;
  logic [3:0]  a1, b1, sum1;
  logic        busy1, done1, cout1, err1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got hang, want finish");
    $fatal(1);
  end

  bcd_serial_adder #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  // ---------------- reference model ----------------
  function automatic int bcd_val(input logic [15:0] v, input int nd);
    int r;
    r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int nd);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd(input int nd);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a 4-digit op and wait (bounded) for done; lat = edges after start edge.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, output int lat);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op1(input logic [3:0] av, input logic [3:0] bv, output int lat);
    a1 = av;
    b1 = bv;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    total_cnt++;
    if ({busy, done, sum, cout, err} !== 20'h0) $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b err=%b, want all 0", busy, done, sum, cout, err);
    else pass_cnt++;
    total_cnt++;
    if ({busy1, done1, sum1, cout1, err1} !== 8'h0) $display("FAIL reset1: got busy=%b done=%b sum=%h cout=%b err=%b, want all 0", busy1, done1, sum1, cout1, err1);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    a = 16'h1234; b = 16'h5678; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; // latched copies must be used
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", k, busy, done);
      else pass_cnt++;
      if (k < 3) tick();
    end
    tick();
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
    else pass_cnt++;
    total_cnt++;
    if (sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0) $display("FAIL basic_result: got sum=%h cout=%b err=%b, want 6912 0 0", sum, cout, err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0 || sum !== 16'h6912) $display("FAIL basic_hold: got done=%b sum=%h, want done=0 sum=6912", done, sum);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    int lat;
    run_op(16'h9999, 16'h0001, lat);
    total_cnt++;
    if (lat !== 4 || sum !== 16'h0000 || cout !== 1'b1) $display("FAIL carry_9999: got lat=%0d sum=%h cout=%b, want 4 0000 1", lat, sum, cout);
    else pass_cnt++;
    run_op(16'h0009, 16'h0009, lat);
    total_cnt++;
    if (lat !== 4 || sum !== 16'h0018 || cout !== 1'b0) $display("FAIL carry_9p9: got lat=%0d sum=%h cout=%b, want 4 0018 0", lat, sum, cout);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_invalid();
    int lat;
    a = 16'h00A0; b = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (err !== 1'b1) $display("FAIL invalid_err_early: got err=%b, want 1", err);
    else pass_cnt++;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    total_cnt++;
    if (lat !== 4 || err !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0) $display("FAIL invalid_result: got lat=%0d err=%b sum=%h cout=%b, want 4 1 0100 0", lat, err, sum, cout);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    a = 16'h1234; b = 16'h5678; start = 1'b1;
    tick();
    // start stays high through RUN with new operands: must be ignored
    a = 16'h1111; b = 16'h1111;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    total_cnt++;
    if (lat !== 4 || sum !== 16'h6912 || cout !== 1'b0) $display("FAIL b2b_first: got lat=%0d sum=%h cout=%b, want 4 6912 0", lat, sum, cout);
    else pass_cnt++;
    // start still high in the done cycle: accepted on this edge
    tick();
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b1 || sum !== 16'h0000) $display("FAIL b2b_accept: got done=%b busy=%b sum=%h, want 0 1 0000", done, busy, sum);
    else pass_cnt++;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n !== 5 || sum !== 16'h2222 || cout !== 1'b0) $display("FAIL b2b_second: got spacing=%0d sum=%h cout=%b, want 5 2222 0", n, sum, cout);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    a = 16'h1F34; b = 16'h5678; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if (sum !== 16'h0002 || err !== 1'b1 || busy !== 1'b1) $display("FAIL rstmid_pre: got sum=%h err=%b busy=%b, want 0002 1 1", sum, err, busy);
    else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, sum, cout, err} !== 20'h0) $display("FAIL rstmid_async: got busy=%b done=%b sum=%h cout=%b err=%b, want all 0", busy, done, sum, cout, err);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL rstmid_nodone: got activity=%b after abort, want 0", seen);
    else pass_cnt++;
    run_op(16'h4321, 16'h1234, lat);
    total_cnt++;
    if (lat !== 4 || sum !== 16'h5555 || cout !== 1'b0 || err !== 1'b0) $display("FAIL rstmid_after: got lat=%0d sum=%h cout=%b err=%b, want 4 5555 0 0", lat, sum, cout, err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random4();
    int lat;
    logic [15:0] av, bv, exp_sum;
    logic exp_cout;
    int tot;
    for (int it = 0; it < 25; it++) begin
      av = rand_bcd(4);
      bv = rand_bcd(4);
      tot = bcd_val(av, 4) + bcd_val(bv, 4);
      exp_sum = to_bcd(tot, 4);
      exp_cout = (tot >= 10000);
      run_op(av, bv, lat);
      total_cnt++;
      if (lat !== 4 || sum !== exp_sum || cout !== exp_cout) $display("FAIL rand4 %h+%h: got lat=%0d sum=%h cout=%b, want 4 %h %b", av, bv, lat, sum, cout, exp_sum, exp_cout);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_random1();
    int lat;
    logic [15:0] av, bv, exp_sum;
    logic exp_cout;
    int tot;
    for (int it = 0; it < 25; it++) begin
      av = rand_bcd(1);
      bv = rand_bcd(1);
      if (it == 0) begin av = 16'h9; bv = 16'h9; end
      tot = bcd_val(av, 1) + bcd_val(bv, 1);
      exp_sum = to_bcd(tot, 1);
      exp_cout = (tot >= 10);
      run_op1(av[3:0], bv[3:0], lat);
      total_cnt++;
      if (lat !== 1 || sum1 !== exp_sum[3:0] || cout1 !== exp_cout) $display("FAIL rand1 %h+%h: got lat=%0d sum=%h cout=%b, want 1 %h %b", av[3:0], bv[3:0], lat, sum1, cout1, exp_sum[3:0], exp_cout);
      else pass_cnt++;
    end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random4();
    test_random1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
